pnr_sys_initiator: RTL and testbench

PNR_SYS_INITIATOR -- requirements
Module: pnr_sys_initiator

---
 rtl/pnr_sys_initiator.sv | 178 +++++++++++++++++
 tb/tb_pnr_sys_initiator.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pnr_sys_initiator.sv
// Purpose: converts one cmd (read or write) into a single-strobe system-bus access and returns one response.
// Latency: rsp_valid rises two cycles after the accept edge when sys_ack arrives on the first WAIT cycle.
//          A misaligned address responds on the cycle after accept.
// Backpressure: cmd_ready is high only in IDLE; a pending response holds rsp_* and blocks new commands until rsp_ready.
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready               command handshake; cmd_we, cmd_addr, cmd_wdata are the command fields
//   rsp_valid/rsp_ready               response handshake; rsp_rdata, rsp_err, rsp_timeout are the response fields
//   sys_addr, sys_wdata, sys_wen/ren  system bus request; sys_wen/sys_ren are one-cycle strobes
//   sys_rdata, sys_err, sys_ack       system bus return, sampled only while waiting for the ack
//   txn_cnt, err_cnt                  completed responses (wrapping) and error/timeout responses (saturating)
// Build option: define PNR_SYS_INITIATOR_TIMEOUT_EN to abort WAIT after TIMEOUT_CYC cycles without sys_ack.
//   Without it, WAIT lasts until sys_ack and rsp_timeout is always 0.

module pnr_sys_initiator #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic [31:0] sys_addr,
    output logic [31:0] sys_wdata,
    output logic        sys_wen,
    output logic        sys_ren,
    input  logic [31:0] sys_rdata,
    input  logic        sys_err,
    input  logic        sys_ack,
    output logic [15:0] txn_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic cmd_fire;
    logic rsp_fire;
    logic misaligned;
    logic ack_hit;
    logic timeout_hit;
    logic txn_we;

    // Next values of the registered handshake/strobe outputs
    logic cmd_ready_d;
    logic sys_wen_d;
    logic sys_ren_d;
    logic rsp_valid_d;

    assign cmd_fire   = cmd_valid & cmd_ready;
    assign rsp_fire   = rsp_valid & rsp_ready;
    assign misaligned = (cmd_addr[1:0] != 2'b00);
    // Bus returns only matter while waiting; anything seen in other states is dropped.
    assign ack_hit    = (state == WAIT) & sys_ack;

`ifdef PNR_SYS_INITIATOR_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wait_cnt;

    // wait_cnt reads 1 on the first WAIT cycle, TIMEOUT_CYC on the last one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= CW'(1);
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // An ack on the final cycle takes priority over the timeout.
    assign timeout_hit = (state == WAIT) & ~sys_ack & (wait_cnt == CW'(TIMEOUT_CYC));
`else
    // TIMEOUT_CYC only has meaning when the timeout counter is built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign timeout_hit        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cmd_fire) state_nxt = misaligned ? RESP : ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (ack_hit || timeout_hit) state_nxt = RESP;
            RESP:  if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs, taken from the state being entered
    always_comb begin
        cmd_ready_d = (state_nxt == IDLE);
        rsp_valid_d = (state_nxt == RESP);
        // ISSUE is only entered from IDLE, so the live cmd_we selects the strobe.
        sys_wen_d   = (state == IDLE) & (state_nxt == ISSUE) & cmd_we;
        sys_ren_d   = (state == IDLE) & (state_nxt == ISSUE) & ~cmd_we;
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            sys_wen     <= 1'b0;
            sys_ren     <= 1'b0;
            txn_we      <= 1'b0;
            sys_addr    <= '0;
            sys_wdata   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            txn_cnt     <= '0;
            err_cnt     <= '0;
        end else begin
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            sys_wen   <= sys_wen_d;
            sys_ren   <= sys_ren_d;

            // Address/data stay registered from accept until the next accept,
            // which keeps them stable through ISSUE and WAIT.
            if (cmd_fire) begin
                txn_we      <= cmd_we;
                sys_addr    <= cmd_addr;
                sys_wdata   <= cmd_wdata;
                rsp_err     <= misaligned;
                rsp_timeout <= 1'b0;
                rsp_rdata   <= '0;
            end

            if (ack_hit) begin
                rsp_err     <= sys_err;
                rsp_timeout <= 1'b0;
                // Read data is only returned for a successful read.
                rsp_rdata   <= (!txn_we && !sys_err) ? sys_rdata : 32'd0;
            end else if (timeout_hit) begin
                rsp_err     <= 1'b0;
                rsp_timeout <= 1'b1;
                rsp_rdata   <= '0;
            end

            if (rsp_fire) begin
                txn_cnt <= txn_cnt + 16'd1;
                if ((rsp_err || rsp_timeout) && (err_cnt != 8'hFF)) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pnr_sys_initiator.sv
// Purpose: self-checking bench for pnr_sys_initiator with a response scoreboard and a simple bus responder.
// Latency: n/a (testbench).
// Backpressure: exercises rsp_ready held low and back-to-back commands.

module tb_pnr_sys_initiator;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata = 32'hBAD0_0000;
    logic        sys_err = 1'b0;
    logic        sys_ack = 1'b0;
    logic [15:0] txn_cnt;
    logic [7:0]  err_cnt;

    pnr_sys_initiator #(.TIMEOUT_CYC(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .sys_addr   (sys_addr),
        .sys_wdata  (sys_wdata),
        .sys_wen    (sys_wen),
        .sys_ren    (sys_ren),
        .sys_rdata  (sys_rdata),
        .sys_err    (sys_err),
        .sys_ack    (sys_ack),
        .txn_cnt    (txn_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        err;
        logic        to;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   wen_cyc = 0;
    int   ren_cyc = 0;

    // Responder behaviour, set by the stimulus thread
    int          ack_delay = 1;
    logic        silent = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] mem [0:15];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (sys_wen) wen_cyc <= wen_cyc + 1;
        if (sys_ren) ren_cyc <= ren_cyc + 1;
    end

    // Scoreboard monitor: compare each response at the cycle it is consumed
    always @(negedge clk_i) begin
        if (!rst_i && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                chk("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    end

    // Bus responder: sees the strobe, acks ack_delay cycles later unless silent
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        forever begin
            @(negedge clk_i);
            if (sys_wen || sys_ren) begin
                logic        was_wr;
                logic [3:0]  idx;
                was_wr = sys_wen;
                idx    = sys_addr[5:2];
                if (was_wr) mem[idx] = sys_wdata;
                if (!silent) begin
                    repeat (ack_delay) @(negedge clk_i);
                    sys_ack   = 1'b1;
                    sys_err   = bus_err;
                    sys_rdata = was_wr ? 32'hDEAD_BEEF : mem[idx];
                    @(negedge clk_i);
                    sys_ack   = 1'b0;
                    sys_err   = 1'b0;
                    sys_rdata = 32'hBAD0_0000;
                end
            end
        end
    end

    task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int acc_cyc);
        int n;
        n = 0;
        acc_cyc = -1;
        @(negedge clk_i);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        while (!cmd_ready && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        @(posedge clk_i);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic push_exp(input logic err, input logic to, input logic [31:0] rdata);
        exp_t e;
        e.err = err;
        e.to = to;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Counts negedges after the accept edge until rsp_valid is seen
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!rsp_valid && n < 40);
    endtask

    initial begin
        int a0, a1, n, w0, r0;

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_strobes", 32'({sys_wen, sys_ren}), 32'd0);
        chk("rst_sys_addr", sys_addr, 32'd0);
        chk("rst_txn_cnt", 32'(txn_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        // Write 0x04 = 0x1FFF, ack one cycle after the strobe
        w0 = wen_cyc; r0 = ren_cyc;
        push_exp(1'b0, 1'b0, 32'd0);
        do_cmd(1'b1, 32'h04, 32'h0000_1FFF, a0);
        wait_valid(n);
        chk("wr_latency", 32'(n), 32'd3);
        wait_idle();
        chk("wr_wen_cycles", 32'(wen_cyc - w0), 32'd1);
        chk("wr_ren_cycles", 32'(ren_cyc - r0), 32'd0);
        chk("wr_txn_cnt", 32'(txn_cnt), 32'd1);

        // Back-to-back: write 0x08 then read 0x04, accept-to-accept must be 4
        w0 = wen_cyc; r0 = ren_cyc;
        push_exp(1'b0, 1'b0, 32'd0);
        do_cmd(1'b1, 32'h08, 32'hA5A5_0001, a0);
        push_exp(1'b0, 1'b0, 32'h0000_1FFF);
        do_cmd(1'b0, 32'h04, 32'h0, a1);
        chk("accept_interval", 32'(a1 - a0), 32'd4);
        wait_idle();
        chk("b2b_wen_cycles", 32'(wen_cyc - w0), 32'd1);
        chk("b2b_ren_cycles", 32'(ren_cyc - r0), 32'd1);
        push_exp(1'b0, 1'b0, 32'hA5A5_0001);
        do_cmd(1'b0, 32'h08, 32'h0, a0);
        wait_idle();
        chk("rd_txn_cnt", 32'(txn_cnt), 32'd4);

        // Misaligned read: no strobe, error response
        w0 = wen_cyc; r0 = ren_cyc;
        push_exp(1'b1, 1'b0, 32'd0);
        do_cmd(1'b0, 32'h06, 32'h0, a0);
        wait_valid(n);
        chk("mis_latency", 32'(n), 32'd1);
        wait_idle();
        chk("mis_strobes", 32'((wen_cyc - w0) + (ren_cyc - r0)), 32'd0);
        chk("mis_err_cnt", 32'(err_cnt), 32'd1);

        // Bus error on a write
        bus_err = 1'b1;
        push_exp(1'b1, 1'b0, 32'd0);
        do_cmd(1'b1, 32'h0C, 32'h1234_5678, a0);
        wait_idle();
        bus_err = 1'b0;
        chk("buserr_err_cnt", 32'(err_cnt), 32'd2);
        chk("buserr_txn_cnt", 32'(txn_cnt), 32'd6);

        // Backpressure: rsp_ready low for 5 cycles
        rsp_ready = 1'b0;
        push_exp(1'b0, 1'b0, 32'h0000_1FFF);
        do_cmd(1'b0, 32'h04, 32'h0, a0);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h0000_1FFF);
            chk("bp_rsp_flags", 32'({rsp_err, rsp_timeout}), 32'd0);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk_i);
        end
        rsp_ready = 1'b1;
        wait_idle();
        chk("bp_cmd_ready_back", 32'(cmd_ready), 32'd1);
        chk("bp_txn_cnt", 32'(txn_cnt), 32'd7);

        // Ack on the 8th WAIT cycle: response, no timeout
        ack_delay = 8;
        push_exp(1'b0, 1'b0, 32'hA5A5_0001);
        do_cmd(1'b0, 32'h08, 32'h0, a0);
        wait_valid(n);
        chk("ack8_latency", 32'(n), 32'd10);
        wait_idle();
        chk("ack8_err_cnt", 32'(err_cnt), 32'd2);
        ack_delay = 1;

`ifdef PNR_SYS_INITIATOR_TIMEOUT_EN
        // Silent responder: timeout after 8 WAIT cycles
        silent = 1'b1;
        push_exp(1'b0, 1'b1, 32'd0);
        do_cmd(1'b1, 32'h10, 32'hCAFE_F00D, a0);
        wait_valid(n);
        chk("to_latency", 32'(n), 32'd10);
        wait_idle();
        silent = 1'b0;
        chk("to_err_cnt", 32'(err_cnt), 32'd3);
        chk("to_txn_cnt", 32'(txn_cnt), 32'd9);
`endif

        // Reset during WAIT; the late ack must not produce a response
        ack_delay = 6;
        do_cmd(1'b0, 32'h04, 32'h0, a0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_strobes", 32'({sys_wen, sys_ren}), 32'd0);
        chk("arst_sys_addr", sys_addr, 32'd0);
        chk("arst_txn_cnt", 32'(txn_cnt), 32'd0);
        chk("arst_err_cnt", 32'(err_cnt), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (12) @(negedge clk_i);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_txn_cnt", 32'(txn_cnt), 32'd0);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        ack_delay = 1;

        // Normal operation after reset
        push_exp(1'b0, 1'b0, 32'h0000_1FFF);
        do_cmd(1'b0, 32'h04, 32'h0, a0);
        wait_idle();
        chk("final_txn_cnt", 32'(txn_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
